// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder sequencer.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_fa_bit.sv
// 1-bit full adder composed of two half-adder cells and an OR for the carry.
module ha_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic s1, c1, c2;

  ha_cell u_ha0 (.a(a),  .b(b),   .s(s1), .c(c1));
  ha_cell u_ha1 (.a(s1), .b(cin), .s(s),  .c(c2));

  assign co = c1 | c2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one shared full-adder cell, one bit per clock, LSB first.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             fa_s, fa_co;
  logic [WIDTH-1:0] r_next;

  fa_bit u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .cin(carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Final sum bit enters the MSB on the same edge the result is published.
  assign r_next = {fa_s, r_sh_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        r_sh_d  = r_next;
        carry_d = fa_co;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          sum_d   = r_next;
          cout_d  = fa_co;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8 (directed + random) and WIDTH=2 (random).
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       s8_start, s8_cin, s8_busy, s8_done, s8_cout;
  logic [7:0] s8_a, s8_b, s8_sum;
  logic       s2_start, s2_cin, s2_busy, s2_done, s2_cout;
  logic [1:0] s2_a, s2_b, s2_sum;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8_start), .a(s8_a), .b(s8_b), .cin(s8_cin),
    .busy(s8_busy), .done(s8_done), .sum(s8_sum), .cout(s8_cout)
  );

  serial_add_ctrl #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(s2_start), .a(s2_a), .b(s2_b), .cin(s2_cin),
    .busy(s2_busy), .done(s2_done), .sum(s2_sum), .cout(s2_cout)
  );

  int         checks = 0;
  int         errors = 0;
  int         done8_cnt = 0;
  int         done2_cnt = 0;
  logic [8:0] q8[$];
  logic [2:0] q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    int n = 0;
    @(negedge clk);
    while (s8_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("w8_issue_timeout", 32'(n >= 100), 0);
    s8_a = a; s8_b = b; s8_cin = cin; s8_start = 1'b1;
    q8.push_back({1'b0, a} + {1'b0, b} + {8'b0, cin});
    @(posedge clk);
    #1;
    s8_start = 1'b0;
    s8_a = 8'($urandom); s8_b = 8'($urandom); s8_cin = 1'($urandom);
  endtask

  task automatic issue2(input logic [1:0] a, input logic [1:0] b, input logic cin);
    int n = 0;
    @(negedge clk);
    while (s2_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("w2_issue_timeout", 32'(n >= 100), 0);
    s2_a = a; s2_b = b; s2_cin = cin; s2_start = 1'b1;
    q2.push_back({1'b0, a} + {1'b0, b} + {2'b0, cin});
    @(posedge clk);
    #1;
    s2_start = 1'b0;
    s2_a = 2'($urandom); s2_b = 2'($urandom); s2_cin = 1'($urandom);
  endtask

  // Waits for the next done of the 8-bit instance; reports busy cycles seen first.
  task automatic wait_done8(output int busy_cycles);
    int n = 0;
    busy_cycles = 0;
    do begin
      @(negedge clk);
      n++;
      if (s8_busy) busy_cycles++;
    end while (!s8_done && n < 100);
    check("w8_done_timeout", 32'(n >= 100), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, d0, per;
    rst_n = 1'b0;
    s8_start = 1'b0; s8_a = '0; s8_b = '0; s8_cin = 1'b0;
    s2_start = 1'b0; s2_a = '0; s2_b = '0; s2_cin = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (s8_done) begin
          done8_cnt++;
          if (q8.size() == 0) begin
            checks++; errors++;
            $display("FAIL w8_unexpected_done: got sum %0h cout %0b expected no done at %0t",
                     s8_sum, s8_cout, $time);
          end else begin
            check("w8_result", {s8_cout, s8_sum}, q8.pop_front());
          end
        end
      end
      forever begin
        @(negedge clk);
        if (s2_done) begin
          done2_cnt++;
          if (q2.size() == 0) begin
            checks++; errors++;
            $display("FAIL w2_unexpected_done: got sum %0h cout %0b expected no done at %0t",
                     s2_sum, s2_cout, $time);
          end else begin
            check("w2_result", {s2_cout, s2_sum}, q2.pop_front());
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("w8_reset_state", {s8_busy, s8_done, s8_cout, s8_sum}, 0);
    check("w2_reset_state", {s2_busy, s2_done, s2_cout, s2_sum}, 0);

    // Zero operands: busy for exactly WIDTH cycles, then done.
    issue8(8'h00, 8'h00, 1'b0);
    wait_done8(bc);
    check("w8_busy_cycles", bc, 8);

    issue8(8'hFF, 8'h01, 1'b0);
    wait_done8(bc);
    issue8(8'h0F, 8'h01, 1'b0);
    wait_done8(bc);
    issue8(8'hA5, 8'h5A, 1'b1);
    wait_done8(bc);

    // Start during RUN must be ignored.
    d0 = done8_cnt;
    issue8(8'h10, 8'h20, 1'b0);
    repeat (3) @(negedge clk);
    s8_a = 8'h01; s8_b = 8'h01; s8_start = 1'b1;
    @(posedge clk);
    #1;
    s8_start = 1'b0;
    wait_done8(bc);
    repeat (12) @(negedge clk);
    check("w8_ignored_start_single_done", done8_cnt - d0, 1);

    // Reset mid-RUN abandons the op and clears outputs.
    d0 = done8_cnt;
    issue8(8'h33, 8'h44, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("w8_midrun_reset_outputs", {s8_busy, s8_done, s8_cout, s8_sum}, 0);
    q8.delete();
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("w8_no_done_after_reset", done8_cnt - d0, 0);

    // Back-to-back: start held during DONE restarts RUN with no IDLE gap.
    issue8(8'h03, 8'h04, 1'b0);
    wait_done8(bc);
    s8_a = 8'h80; s8_b = 8'h80; s8_cin = 1'b0; s8_start = 1'b1;
    q8.push_back(9'h100);
    @(posedge clk);
    #1;
    s8_start = 1'b0;
    @(negedge clk);
    check("w8_b2b_busy_no_idle", 32'(s8_busy), 1);
    per = 1;
    while (!s8_done && per < 100) begin
      @(negedge clk);
      per++;
    end
    check("w8_b2b_period", per, 9);

    fork
      for (int i = 0; i < 500; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        issue8(8'($urandom), 8'($urandom), 1'($urandom));
      end
      for (int j = 0; j < 500; j++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        issue2(2'($urandom), 2'($urandom), 1'($urandom));
      end
    join
    repeat (20) @(negedge clk);
    check("w8_queue_drained", q8.size(), 0);
    check("w2_queue_drained", q2.size(), 0);
    check("w2_done_count", done2_cnt, 500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
